axi_lite_traffic_checker: RTL and testbench

//  Parametrised AXI4-Lite master that replaces the fixed single write/read self-check.
//  On start it writes NUM_TXN beats over an address window, then reads them back.
//  It compares every read against the regenerated pattern and reports error count, first failing address and pass/done.

---
 rtl/axi_tg_pkg.sv | 22 ++
 rtl/axi_tg_pattern_gen.sv | 46 ++++
 rtl/axi_lite_traffic_checker.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_lite_traffic_checker.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_tg_pkg.sv
// rtl/axi_tg_pkg.sv - Shared types and constants for the AXI4-Lite traffic checker
// Contents: FSM state enum, AXI response code, LFSR feedback polynomials.
package axi_tg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP_W,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_GAP_R,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_DONE
    } tg_state_e;

    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

    // Galois feedback masks, applied on a right shift when the bit shifted out is 1
    localparam logic [31:0] LFSR_POLY32 = 32'h8020_0003;
    localparam logic [63:0] LFSR_POLY64 = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/axi_tg_pattern_gen.sv
// rtl/axi_tg_pattern_gen.sv - Regenerable data pattern source for the traffic checker
// Ports: clk_i clock; rst_ni async active-low reset; load_i restart at the seed;
//        advance_i step to the next pattern word; value_o current pattern word.
module axi_tg_pattern_gen #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          PATTERN_MODE = 0,
    parameter logic [63:0] SEED         = 64'h100
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  advance_i,
    output logic [DATA_WIDTH-1:0] value_o
);
    import axi_tg_pkg::*;

    localparam logic [DATA_WIDTH-1:0] POLY =
        (DATA_WIDTH == 64) ? DATA_WIDTH'(LFSR_POLY64) : DATA_WIDTH'(LFSR_POLY32);
    localparam logic [DATA_WIDTH-1:0] SEED_RAW = DATA_WIDTH'(SEED);
    // An all-zero LFSR state would lock up, so a zero seed becomes 1 in LFSR mode
    localparam logic [DATA_WIDTH-1:0] SEED_VAL =
        ((PATTERN_MODE == 1) && (SEED_RAW == '0)) ? DATA_WIDTH'(1) : SEED_RAW;

    logic [DATA_WIDTH-1:0] value_q;
    logic [DATA_WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q + DATA_WIDTH'(1);
        if (PATTERN_MODE == 1) begin
            value_d = value_q[0] ? ((value_q >> 1) ^ POLY) : (value_q >> 1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= SEED_VAL;
        end else if (load_i) begin
            value_q <= SEED_VAL;
        end else if (advance_i) begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/axi_lite_traffic_checker.sv
// rtl/axi_lite_traffic_checker.sv - AXI4-Lite master writing a pattern window and reading it back
// Ports: aclk/areset_n clock and async active-low reset; start one-cycle run request;
//        aw*/w*/b*/ar*/r* AXI4-Lite master channels; busy/done/pass run status;
//        err_count saturating error count; first_err_addr address of the first error.
module axi_lite_traffic_checker #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    NUM_TXN      = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE    = 'h10,
    parameter int                    ADDR_STRIDE  = 4,
    parameter int                    PATTERN_MODE = 0,
    parameter logic [63:0]           SEED         = 64'h100,
    parameter int                    GAP_CYCLES   = 8,
    parameter int                    ERR_WIDTH    = 16
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    start,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ERR_WIDTH-1:0]    err_count,
    output logic [ADDR_WIDTH-1:0]   first_err_addr
);
    import axi_tg_pkg::*;

    localparam int                    BEAT_W    = (NUM_TXN > 1) ? $clog2(NUM_TXN) : 1;
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(NUM_TXN - 1);
    // A zero gap still spends one cycle in the gap state
    localparam logic [31:0]           GAP_LAST  = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
    localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(ADDR_STRIDE);
    localparam logic [ERR_WIDTH-1:0]  ERR_MAX   = '1;

    tg_state_e             state_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [31:0]           gap_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  awvalid_q, wvalid_q, aw_done_q, w_done_q;
    logic                  bready_q, arvalid_q, rready_q;
    logic                  busy_q, done_q;
    logic [ERR_WIDTH-1:0]  err_q;
    logic [ADDR_WIDTH-1:0] first_q;

    logic [DATA_WIDTH-1:0] pat_value;
    logic                  last_beat, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  err_event, pat_load, pat_adv;

    assign last_beat = (beat_q == LAST_BEAT);
    assign aw_hs     = awvalid_q & awready;
    assign w_hs      = wvalid_q & wready;
    assign b_hs      = bready_q & bvalid;
    assign ar_hs     = arvalid_q & arready;
    assign r_hs      = rready_q & rvalid;

    // A bad read counts once even when data and response are both wrong
    assign err_event = (b_hs && (bresp != AXI_RESP_OKAY)) ||
                       (r_hs && ((rdata != pat_value) || (rresp != AXI_RESP_OKAY)));

    // The single pattern source restarts at each phase and steps once per completed beat
    assign pat_load = ((state_q == ST_IDLE) && start) ||
                      ((state_q == ST_WR_RESP) && b_hs && last_beat);
    assign pat_adv  = (((state_q == ST_WR_RESP) && b_hs) ||
                       ((state_q == ST_RD_RESP) && r_hs)) && !last_beat;

    axi_tg_pattern_gen #(
        .DATA_WIDTH   (DATA_WIDTH),
        .PATTERN_MODE (PATTERN_MODE),
        .SEED         (SEED)
    ) u_pattern (
        .clk_i     (aclk),
        .rst_ni    (areset_n),
        .load_i    (pat_load),
        .advance_i (pat_adv),
        .value_o   (pat_value)
    );

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            gap_q     <= '0;
            addr_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= '0;
            first_q   <= '0;
        end else begin
            // addr_q still holds the current beat's address on its response cycle
            if (err_event) begin
                if (err_q == '0) begin
                    first_q <= addr_q;
                end
                if (err_q != ERR_MAX) begin
                    err_q <= err_q + ERR_WIDTH'(1);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        done_q  <= 1'b0;
                        err_q   <= '0;
                        first_q <= '0;
                        busy_q  <= 1'b1;
                        beat_q  <= '0;
                        gap_q   <= '0;
                        addr_q  <= ADDR_BASE;
                        state_q <= ST_GAP_W;
                    end
                end
                ST_GAP_W, ST_GAP_R: begin
                    if (gap_q == GAP_LAST) begin
                        gap_q <= '0;
                        if (state_q == ST_GAP_W) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_REQ;
                        end
                    end else begin
                        gap_q <= gap_q + 32'd1;
                    end
                end
                ST_WR_REQ: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    // AW and W complete independently; move on once both have been accepted
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= ST_WR_RESP;
                    end else begin
                        if (aw_hs) aw_done_q <= 1'b1;
                        if (w_hs)  w_done_q  <= 1'b1;
                    end
                end
                ST_WR_RESP: begin
                    if (b_hs) begin
                        bready_q <= 1'b0;
                        if (last_beat) begin
                            beat_q  <= '0;
                            addr_q  <= ADDR_BASE;
                            state_q <= ST_GAP_R;
                        end else begin
                            beat_q    <= beat_q + BEAT_W'(1);
                            addr_q    <= addr_q + STRIDE;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WR_REQ;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (r_hs) begin
                        rready_q <= 1'b0;
                        if (last_beat) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            beat_q    <= beat_q + BEAT_W'(1);
                            addr_q    <= addr_q + STRIDE;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign awvalid        = awvalid_q;
    assign awaddr         = addr_q;
    assign wvalid         = wvalid_q;
    assign wdata          = pat_value;
    assign wstrb          = '1;
    assign bready         = bready_q;
    assign arvalid        = arvalid_q;
    assign araddr         = addr_q;
    assign rready         = rready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = done_q && (err_q == '0);
    assign err_count      = err_q;
    assign first_err_addr = first_q;

endmodule

// File: tb/tb_axi_lite_traffic_checker.sv
// tb/tb_axi_lite_traffic_checker.sv - Self-checking bench for axi_lite_traffic_checker
module tb_axi_lite_traffic_checker;

    logic aclk = 1'b0;
    logic areset_n;
    always #5 aclk = ~aclk;

    logic        start_a      [3];
    bit          stall_en     [3];
    bit          bresp_err    [3];
    bit          corrupt_en   [3];
    bit          corrupt_all  [3];
    logic [31:0] corrupt_addr [3];

    logic        busy_a [3];
    logic        done_a [3];
    logic        pass_a [3];
    logic [15:0] err_a  [3];
    logic [31:0] fea_a  [3];
    logic [4:0]  vld_a  [3];
    int          wr_cnt_a [3];
    int          viol_a   [3];

    int n_checks = 0;
    int n_pass   = 0;

    // Instance 0: defaults. 1: 64-bit LFSR, 4 beats. 2: 4 beats, 2-bit counter, no gap.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DW  = (g == 1) ? 64 : 32;
        localparam int NT  = (g == 0) ? 16 : 4;
        localparam int STR = (g == 1) ? 8 : 4;
        localparam int PM  = (g == 1) ? 1 : 0;
        localparam int GAP = (g == 2) ? 0 : 8;
        localparam int EW  = (g == 2) ? 2 : 16;

        logic          awvalid, awready, wvalid, wready, bvalid, bready;
        logic          arvalid, arready, rvalid, rready, busy, done, pass;
        logic [31:0]   awaddr, araddr, first_err_addr;
        logic [DW-1:0] wdata, rdata;
        logic [DW/8-1:0] wstrb;
        logic [1:0]    bresp, rresp;
        logic [EW-1:0] err_count;

        axi_lite_traffic_checker #(
            .ADDR_WIDTH(32), .DATA_WIDTH(DW), .NUM_TXN(NT), .ADDR_BASE(32'h10),
            .ADDR_STRIDE(STR), .PATTERN_MODE(PM), .SEED(64'h100),
            .GAP_CYCLES(GAP), .ERR_WIDTH(EW)
        ) u_dut (
            .aclk(aclk), .areset_n(areset_n), .start(start_a[g]),
            .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
            .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
            .bvalid(bvalid), .bready(bready), .bresp(bresp),
            .arvalid(arvalid), .arready(arready), .araddr(araddr),
            .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
            .busy(busy), .done(done), .pass(pass),
            .err_count(err_count), .first_err_addr(first_err_addr)
        );

        logic [DW-1:0] mem [0:255];
        logic          have_aw, have_w, have_ar;
        logic [31:0]   aw_l, ar_l;
        logic [DW-1:0] w_l;
        int            wr_cnt = 0;
        int            viol   = 0;

        // Slave: optional random ready/response stalls, byte-addressed memory
        always @(posedge aclk or negedge areset_n) begin
            if (!areset_n) begin
                awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
                bvalid  <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00;
                have_aw <= 1'b0; have_w <= 1'b0; have_ar <= 1'b0; rdata <= '0;
            end else begin
                awready <= stall_en[g] ? 1'($urandom_range(0, 1)) : 1'b1;
                wready  <= stall_en[g] ? 1'($urandom_range(0, 1)) : 1'b1;
                arready <= stall_en[g] ? 1'($urandom_range(0, 1)) : 1'b1;
                if (awvalid && awready) begin have_aw <= 1'b1; aw_l <= awaddr; end
                if (wvalid && wready) begin have_w <= 1'b1; w_l <= wdata; end
                if (bvalid && bready) begin
                    bvalid <= 1'b0; have_aw <= 1'b0; have_w <= 1'b0;
                end else if (have_aw && have_w && !bvalid &&
                             (!stall_en[g] || $urandom_range(0, 1) == 1)) begin
                    mem[aw_l[7:0]] <= w_l;
                    wr_cnt <= wr_cnt + 1;
                    bvalid <= 1'b1;
                    bresp  <= bresp_err[g] ? 2'b10 : 2'b00;
                end
                if (arvalid && arready) begin have_ar <= 1'b1; ar_l <= araddr; end
                if (rvalid && rready) begin
                    rvalid <= 1'b0; have_ar <= 1'b0;
                end else if (have_ar && !rvalid &&
                             (!stall_en[g] || $urandom_range(0, 1) == 1)) begin
                    rvalid <= 1'b1;
                    rresp  <= 2'b00;
                    rdata  <= mem[ar_l[7:0]] ^
                              ((corrupt_all[g] || (corrupt_en[g] && ar_l == corrupt_addr[g])) ? DW'(1) : DW'(0));
                end
            end
        end

        // Protocol watch: a valid waiting for ready must stay high with a stable payload
        logic          p_aw, p_w, p_ar;
        logic [31:0]   p_awaddr, p_araddr;
        logic [DW-1:0] p_wdata;
        always @(posedge aclk or negedge areset_n) begin
            if (!areset_n) begin
                p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
            end else begin
                viol <= viol + int'(p_aw && (!awvalid || awaddr != p_awaddr))
                             + int'(p_w && (!wvalid || wdata != p_wdata))
                             + int'(p_ar && (!arvalid || araddr != p_araddr))
                             + int'(wvalid && (wstrb != '1));
                p_aw <= awvalid && !awready; p_awaddr <= awaddr;
                p_w  <= wvalid && !wready;   p_wdata  <= wdata;
                p_ar <= arvalid && !arready; p_araddr <= araddr;
            end
        end

        assign busy_a[g]   = busy;
        assign done_a[g]   = done;
        assign pass_a[g]   = pass;
        assign err_a[g]    = 16'(err_count);
        assign fea_a[g]    = first_err_addr;
        assign vld_a[g]    = {awvalid, wvalid, bready, arvalid, rready};
        assign wr_cnt_a[g] = wr_cnt;
        assign viol_a[g]   = viol;
    end

    // Reference pattern: SEED+i, or i right-shift Galois steps from SEED (zero seed -> 1)
    function automatic logic [63:0] pat(input int mode, input int dw, input logic [63:0] seed, input int i);
        logic [63:0] v, mask, poly;
        mask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        if (mode == 0) return (seed + 64'(i)) & mask;
        poly = (dw == 64) ? 64'hD800_0000_0000_0000 : 64'h0000_0000_8020_0003;
        v = seed & mask;
        if (v == 0) v = 1;
        for (int k = 0; k < i; k++) v = v[0] ? ((v >> 1) ^ poly) : (v >> 1);
        return v;
    endfunction

    task automatic pulse_start(input int g);
        @(negedge aclk); start_a[g] = 1'b1;
        @(negedge aclk); start_a[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done_a[g] === 1'b1) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        repeat (3) @(negedge aclk);
        for (int g = 0; g < 3; g++) begin
            n_checks++; if (vld_a[g] !== 5'b0) $display("FAIL reset.valids[%0d]: got %b expected 00000", g, vld_a[g]); else n_pass++;
            n_checks++; if ({busy_a[g], done_a[g], pass_a[g]} !== 3'b000) $display("FAIL reset.status[%0d]: got %b expected 000", g, {busy_a[g], done_a[g], pass_a[g]}); else n_pass++;
            n_checks++; if (err_a[g] !== 16'd0 || fea_a[g] !== 32'd0) $display("FAIL reset.err[%0d]: got %0d/%h expected 0/0", g, err_a[g], fea_a[g]); else n_pass++;
        end
        areset_n = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_zero_wait();
        bit ok; int base; logic [63:0] p;
        base = wr_cnt_a[0];
        pulse_start(0);
        n_checks++; if (busy_a[0] !== 1'b1) $display("FAIL zero_wait.busy_after_start: got %b expected 1", busy_a[0]); else n_pass++;
        wait_done(0, 3000, ok);
        n_checks++; if (!ok) $display("FAIL zero_wait.timeout: done=0 after 3000 cycles, expected 1"); else n_pass++;
        n_checks++; if (pass_a[0] !== 1'b1 || busy_a[0] !== 1'b0) $display("FAIL zero_wait.pass_busy: got %b%b expected 10", pass_a[0], busy_a[0]); else n_pass++;
        n_checks++; if (err_a[0] !== 16'd0 || fea_a[0] !== 32'd0) $display("FAIL zero_wait.err: got %0d/%h expected 0/0", err_a[0], fea_a[0]); else n_pass++;
        n_checks++; if (wr_cnt_a[0] - base !== 16) $display("FAIL zero_wait.writes: got %0d expected 16", wr_cnt_a[0] - base); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            p = pat(0, 32, 64'h100, i);
            n_checks++; if (g_dut[0].mem[8'(32'h10 + 4 * i)] !== p[31:0]) $display("FAIL zero_wait.mem[%0d]: got %h expected %h", i, g_dut[0].mem[8'(32'h10 + 4 * i)], p[31:0]); else n_pass++;
        end
        repeat (4) @(negedge aclk);
        n_checks++; if (done_a[0] !== 1'b1 || busy_a[0] !== 1'b0) $display("FAIL zero_wait.done_sticky: got %b%b expected 10", done_a[0], busy_a[0]); else n_pass++;
    endtask

    task automatic test_corrupt();
        bit ok;
        corrupt_en[0] = 1'b1; corrupt_addr[0] = 32'h18;
        pulse_start(0);
        n_checks++; if (done_a[0] !== 1'b0) $display("FAIL corrupt.done_cleared: got %b expected 0", done_a[0]); else n_pass++;
        wait_done(0, 3000, ok);
        n_checks++; if (!ok) $display("FAIL corrupt.timeout: done=0 after 3000 cycles, expected 1"); else n_pass++;
        n_checks++; if (err_a[0] !== 16'd1) $display("FAIL corrupt.err_count: got %0d expected 1", err_a[0]); else n_pass++;
        n_checks++; if (fea_a[0] !== 32'h18) $display("FAIL corrupt.first_err_addr: got %h expected 00000018", fea_a[0]); else n_pass++;
        n_checks++; if (pass_a[0] !== 1'b0) $display("FAIL corrupt.pass: got %b expected 0", pass_a[0]); else n_pass++;
        corrupt_en[0] = 1'b0;
    endtask

    task automatic test_random_stalls();
        bit ok; int exp_err; logic [31:0] exp_fea, a;
        stall_en[0] = 1'b1;
        for (int it = 0; it < 4; it++) begin
            corrupt_en[0]   = 1'($urandom_range(0, 1));
            corrupt_addr[0] = 32'h10 + 32'(4 * $urandom_range(0, 15));
            exp_err = 0; exp_fea = 32'd0;
            for (int i = 0; i < 16; i++) begin
                a = 32'h10 + 32'(4 * i);
                if (corrupt_en[0] && a == corrupt_addr[0]) begin
                    if (exp_err == 0) exp_fea = a;
                    exp_err++;
                end
            end
            pulse_start(0);
            wait_done(0, 5000, ok);
            n_checks++; if (!ok) $display("FAIL stalls[%0d].timeout: done=0 after 5000 cycles, expected 1", it); else n_pass++;
            n_checks++; if (err_a[0] !== 16'(exp_err) || fea_a[0] !== exp_fea) $display("FAIL stalls[%0d].err: got %0d/%h expected %0d/%h", it, err_a[0], fea_a[0], exp_err, exp_fea); else n_pass++;
            n_checks++; if (pass_a[0] !== (exp_err == 0)) $display("FAIL stalls[%0d].pass: got %b expected %b", it, pass_a[0], exp_err == 0); else n_pass++;
        end
        n_checks++; if (viol_a[0] !== 0) $display("FAIL stalls.protocol: got %0d violations expected 0", viol_a[0]); else n_pass++;
        stall_en[0] = 1'b0; corrupt_en[0] = 1'b0;
    endtask

    task automatic test_slverr_lfsr();
        bit ok; logic [63:0] p;
        bresp_err[1] = 1'b1;
        pulse_start(1);
        wait_done(1, 3000, ok);
        n_checks++; if (!ok) $display("FAIL slverr.timeout: done=0 after 3000 cycles, expected 1"); else n_pass++;
        n_checks++; if (err_a[1] !== 16'd4) $display("FAIL slverr.err_count: got %0d expected 4", err_a[1]); else n_pass++;
        n_checks++; if (fea_a[1] !== 32'h10 || pass_a[1] !== 1'b0) $display("FAIL slverr.first_pass: got %h/%b expected 00000010/0", fea_a[1], pass_a[1]); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            p = pat(1, 64, 64'h100, i);
            n_checks++; if (g_dut[1].mem[8'(32'h10 + 8 * i)] !== p) $display("FAIL slverr.mem[%0d]: got %h expected %h", i, g_dut[1].mem[8'(32'h10 + 8 * i)], p); else n_pass++;
        end
        bresp_err[1] = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok; int base;
        base = wr_cnt_a[0];
        pulse_start(0);
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge aclk);
            if (vld_a[0][2] === 1'b1 && wr_cnt_a[0] - base == 5) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) $display("FAIL reset_mid.reach_beat5: bready not seen at beat 5 within 500 cycles"); else n_pass++;
        areset_n = 1'b0;
        #1;
        n_checks++; if (vld_a[0] !== 5'b0) $display("FAIL reset_mid.valids: got %b expected 00000", vld_a[0]); else n_pass++;
        n_checks++; if ({busy_a[0], done_a[0], pass_a[0]} !== 3'b000 || err_a[0] !== 16'd0) $display("FAIL reset_mid.status: got %b/%0d expected 000/0", {busy_a[0], done_a[0], pass_a[0]}, err_a[0]); else n_pass++;
        repeat (2) @(negedge aclk);
        areset_n = 1'b1;
        pulse_start(0);
        wait_done(0, 3000, ok);
        n_checks++; if (!ok) $display("FAIL reset_mid.rerun_timeout: done=0 after 3000 cycles, expected 1"); else n_pass++;
        n_checks++; if (pass_a[0] !== 1'b1 || err_a[0] !== 16'd0) $display("FAIL reset_mid.rerun_pass: got %b/%0d expected 1/0", pass_a[0], err_a[0]); else n_pass++;
    endtask

    task automatic test_start_ignored();
        bit ok; int base;
        base = wr_cnt_a[0];
        pulse_start(0);
        repeat (20) @(negedge aclk);
        pulse_start(0);
        n_checks++; if (busy_a[0] !== 1'b1) $display("FAIL start_ignored.busy: got %b expected 1", busy_a[0]); else n_pass++;
        wait_done(0, 3000, ok);
        n_checks++; if (!ok) $display("FAIL start_ignored.timeout: done=0 after 3000 cycles, expected 1"); else n_pass++;
        n_checks++; if (wr_cnt_a[0] - base !== 16) $display("FAIL start_ignored.writes: got %0d expected 16", wr_cnt_a[0] - base); else n_pass++;
        n_checks++; if (pass_a[0] !== 1'b1 || viol_a[0] !== 0) $display("FAIL start_ignored.pass: got %b/%0d expected 1/0", pass_a[0], viol_a[0]); else n_pass++;
    endtask

    task automatic test_saturate();
        bit ok; logic [63:0] p;
        corrupt_all[2] = 1'b1;
        pulse_start(2);
        wait_done(2, 3000, ok);
        n_checks++; if (!ok) $display("FAIL saturate.timeout: done=0 after 3000 cycles, expected 1"); else n_pass++;
        n_checks++; if (err_a[2] !== 16'd3) $display("FAIL saturate.err_count: got %0d expected 3", err_a[2]); else n_pass++;
        n_checks++; if (fea_a[2] !== 32'h10 || pass_a[2] !== 1'b0) $display("FAIL saturate.first_pass: got %h/%b expected 00000010/0", fea_a[2], pass_a[2]); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            p = pat(0, 32, 64'h100, i);
            n_checks++; if (g_dut[2].mem[8'(32'h10 + 4 * i)] !== p[31:0]) $display("FAIL saturate.mem[%0d]: got %h expected %h", i, g_dut[2].mem[8'(32'h10 + 4 * i)], p[31:0]); else n_pass++;
        end
        corrupt_all[2] = 1'b0;
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            start_a[g] = 1'b0; stall_en[g] = 1'b0; bresp_err[g] = 1'b0;
            corrupt_en[g] = 1'b0; corrupt_all[g] = 1'b0; corrupt_addr[g] = 32'd0;
        end
        test_reset();
        test_zero_wait();
        test_corrupt();
        test_random_stalls();
        test_slverr_lfsr();
        test_reset_mid();
        test_start_ignored();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
